// File: rtl/profile_sampler_ci_if.sv
// Custom-instruction port bundle shared between the CPU (master) and a CI block (slave).
interface profile_sampler_ci_if;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, ciN, valueA, valueB,
        input  done, result
    );

    modport slave (
        input  start, ciN, valueA, valueB,
        output done, result
    );
endinterface

// File: rtl/profile_sampler_ci.sv
// Profiling CI block: four event counters plus a timer-driven snapshot engine
// that writes whole 4-word samples into a FIFO for later draining by software.
module profile_sampler_ci #(
    parameter logic [7:0] customId   = 8'd9,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    profile_sampler_ci_if.slave ci,
    input  logic                stall,
    input  logic                busIdle
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ROOM_LIMIT = CNT_W'(FIFO_DEPTH - 4);

    localparam logic [2:0] OP_READ   = 3'd0;
    localparam logic [2:0] OP_CONFIG = 3'd1;
    localparam logic [2:0] OP_PERIOD = 3'd2;
    localparam logic [2:0] OP_POP    = 3'd3;
    localparam logic [2:0] OP_STATUS = 3'd4;
    localparam logic [2:0] OP_ACK    = 3'd5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAP0 = 3'd1,
        CAP1 = 3'd2,
        CAP2 = 3'd3,
        CAP3 = 3'd4
    } state_t;

    logic [31:0]      counter [4];
    logic [31:0]      shadow  [4];
    logic [31:0]      mem     [FIFO_DEPTH];
    logic [3:0]       en;
    logic [31:0]      period;
    logic [31:0]      timer;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      drops;
    logic             pop_pending;
    logic [31:0]      pop_data;
    state_t           state;
    state_t           next_state;

    logic             accept;
    logic [2:0]       opcode;
    logic             tick;
    logic [3:0]       clear_mask;
    logic [3:0]       event_hit;
    logic             pop_take;
    logic             capture;
    logic             drop;
    logic             push;
    logic [31:0]      push_data;
    logic             unused_bits;

    // A start is ignored while a POP result is still on its way out.
    assign accept      = ci.start && (ci.ciN == customId) && !pop_pending;
    assign opcode      = ci.valueA[2:0];
    assign tick        = (period != 32'd0) && (timer == 32'd1);
    assign clear_mask  = (accept && opcode == OP_CONFIG) ? ci.valueB[7:4] : 4'b0000;
    assign event_hit   = {1'b1, busIdle, stall, 1'b1};
    assign pop_take    = accept && (opcode == OP_POP) && (count != '0);
    assign unused_bits = ^ci.valueA[31:3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) counter[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (clear_mask[i])
                    counter[i] <= '0;
                else if (en[i] && event_hit[i])
                    counter[i] <= counter[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en     <= '0;
            period <= '0;
            timer  <= '0;
        end else begin
            if (accept && opcode == OP_CONFIG)
                en <= ci.valueB[3:0];
            if (accept && opcode == OP_PERIOD) begin
                period <= ci.valueB;
                timer  <= ci.valueB;
            end else if (period != 32'd0) begin
                timer <= (timer <= 32'd1) ? period : timer - 32'd1;
            end
        end
    end

    // A lost sample must stay visible even if software acknowledges in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            drops    <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drops != 16'hFFFF)
                drops <= drops + 16'd1;
        end else if (accept && opcode == OP_ACK) begin
            overflow <= 1'b0;
            drops    <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        drop       = 1'b0;
        push       = 1'b0;
        push_data  = shadow[0];
        unique case (state)
            IDLE: begin
                if (tick) begin
                    if (count <= ROOM_LIMIT) begin
                        capture    = 1'b1;
                        next_state = CAP0;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            CAP0: begin
                push       = 1'b1;
                push_data  = shadow[0];
                drop       = tick;
                next_state = CAP1;
            end
            CAP1: begin
                push       = 1'b1;
                push_data  = shadow[1];
                drop       = tick;
                next_state = CAP2;
            end
            CAP2: begin
                push       = 1'b1;
                push_data  = shadow[2];
                drop       = tick;
                next_state = CAP3;
            end
            CAP3: begin
                push       = 1'b1;
                push_data  = shadow[3];
                drop       = tick;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadows freeze the sample so clears or reconfiguration mid-capture cannot tear it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < 4; i++) shadow[i] <= counter[i];
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_take)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_take})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pop_pending <= 1'b0;
            pop_data    <= '0;
        end else begin
            pop_pending <= accept && (opcode == OP_POP);
            if (accept && opcode == OP_POP)
                pop_data <= (count != '0) ? mem[rd_ptr] : 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        ci.done   = 1'b0;
        ci.result = '0;
        if (pop_pending) begin
            ci.done   = 1'b1;
            ci.result = pop_data;
        end else if (accept && opcode != OP_POP) begin
            ci.done = 1'b1;
            case (opcode)
                OP_READ:   ci.result = counter[ci.valueB[1:0]];
                OP_STATUS: ci.result = {drops, overflow, 7'b0, 8'(count)};
                default:   ci.result = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_profile_sampler_ci.sv
// Directed bench for profile_sampler_ci: a transaction-level reference model feeds
// an expected-result queue that is compared against each CI completion.
module tb_profile_sampler_ci;
    localparam int         DEPTH = 16;
    localparam logic [7:0] ID    = 8'd9;
    localparam logic [1:0] LAT_NOW  = 2'd0;
    localparam logic [1:0] LAT_NEXT = 2'd1;
    localparam logic [1:0] LAT_NONE = 2'd2;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0;
    logic busIdle = 1'b0;

    int passed = 0;
    int total  = 0;
    exp_t sb[$];

    profile_sampler_ci_if ci ();

    profile_sampler_ci #(
        .customId   (ID),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ci      (ci),
        .stall   (stall),
        .busIdle (busIdle)
    );

    always #5 clock = ~clock;

    // Reference model, updated once per edge from the inputs the bench drives.
    logic [31:0] m_c [4];
    logic [31:0] m_snap [4];
    logic [3:0]  m_en;
    logic [31:0] m_period, m_timer;
    logic [31:0] m_q[$];
    logic [31:0] m_tmp;
    logic        m_ovf, m_pend, m_acc, m_tick, m_was_idle;
    logic [15:0] m_drops;
    logic [2:0]  m_op;
    logic [3:0]  m_ev;
    int          m_busy, m_fill0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_c[i] = '0;
            m_en = '0; m_period = '0; m_timer = '0;
            m_q.delete();
            m_ovf = 1'b0; m_drops = '0; m_busy = 0; m_pend = 1'b0;
        end else begin
            m_acc   = ci.start && (ci.ciN == ID) && !m_pend;
            m_op    = ci.valueA[2:0];
            m_tick  = (m_period != 0) && (m_timer == 32'd1);
            m_fill0 = m_q.size();
            m_ev    = {1'b1, busIdle, stall, 1'b1};
            for (int i = 0; i < 4; i++) m_snap[i] = m_c[i];
            for (int i = 0; i < 4; i++) begin
                if (m_acc && m_op == 3'd1 && ci.valueB[4+i]) m_c[i] = '0;
                else if (m_en[i] && m_ev[i]) m_c[i] = m_c[i] + 32'd1;
            end
            if (m_acc && m_op == 3'd1) m_en = ci.valueB[3:0];
            if (m_acc && m_op == 3'd2) begin
                m_period = ci.valueB;
                m_timer  = ci.valueB;
            end else if (m_period != 0) begin
                m_timer = (m_timer == 32'd1) ? m_period : m_timer - 32'd1;
            end
            if (m_acc && m_op == 3'd3 && m_q.size() != 0) m_tmp = m_q.pop_front();
            m_pend = m_acc && (m_op == 3'd3);
            if (m_acc && m_op == 3'd5) begin
                m_ovf = 1'b0;
                m_drops = '0;
            end
            m_was_idle = (m_busy == 0);
            if (m_busy != 0) m_busy = m_busy - 1;
            if (m_tick) begin
                if (m_was_idle && (DEPTH - m_fill0) >= 4) begin
                    for (int i = 0; i < 4; i++) m_q.push_back(m_snap[i]);
                    m_busy = 4;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic applyStimulus(input logic [7:0] cin, input logic [2:0] op, input logic [31:0] vb);
        exp_t e;
        @(negedge clock);
        ci.start  = 1'b1;
        ci.ciN    = cin;
        ci.valueA = {29'd0, op};
        ci.valueB = vb;
        e.lat = LAT_NOW;
        e.res = '0;
        if (cin != ID) begin
            e.lat = LAT_NONE;
        end else begin
            case (op)
                3'd0: e.res = m_c[vb[1:0]];
                3'd3: begin
                    e.lat = LAT_NEXT;
                    e.res = (m_q.size() != 0) ? m_q[0] : 32'hFFFF_FFFF;
                end
                3'd4: e.res = {m_drops, m_ovf, 7'd0, 8'(m_q.size())};
                default: e.res = '0;
            endcase
        end
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        e = sb.pop_front();
        #1;
        if (e.lat == LAT_NOW) begin
            check({tag, "_done"}, 32'(ci.done), 32'd1);
            check({tag, "_result"}, ci.result, e.res);
        end else begin
            check({tag, "_quiet_done"}, 32'(ci.done), 32'd0);
            check({tag, "_quiet_result"}, ci.result, 32'd0);
        end
        @(negedge clock);
        ci.start = 1'b0;
        #1;
        if (e.lat == LAT_NEXT) begin
            check({tag, "_done"}, 32'(ci.done), 32'd1);
            check({tag, "_result"}, ci.result, e.res);
        end else begin
            check({tag, "_pulse_end"}, 32'(ci.done), 32'd0);
        end
    endtask

    task automatic cmd(input string tag, input logic [7:0] cin, input logic [2:0] op, input logic [31:0] vb);
        applyStimulus(cin, op, vb);
        checkOutput(tag);
    endtask

    // POP followed by an ACK attempt in the cycle its result is returned.
    task automatic popThenIgnored;
        exp_t e;
        applyStimulus(ID, 3'd3, 32'd0);
        @(negedge clock);
        ci.valueA = 32'd5;
        #1;
        e = sb.pop_front();
        check("pend_done", 32'(ci.done), 32'd1);
        check("pend_result", ci.result, e.res);
        @(negedge clock);
        ci.start = 1'b0;
        #1;
        check("pend_after", 32'(ci.done), 32'd0);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        ci.start = 1'b0; ci.ciN = '0; ci.valueA = '0; ci.valueB = '0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_done", 32'(ci.done), 32'd0);
        check("reset_result", ci.result, 32'd0);
        cmd("reset_status", ID, 3'd4, 32'd0);
        cmd("reset_read0", ID, 3'd0, 32'd0);

        cmd("cfg_all", ID, 3'd1, 32'h0F);
        waitCycles(100);
        cmd("read_c0", ID, 3'd0, 32'd0);
        cmd("wrong_id", 8'd8, 3'd0, 32'd0);

        cmd("cfg_c1", ID, 3'd1, 32'h22);
        @(negedge clock) stall = 1'b1;
        waitCycles(9);
        @(negedge clock) stall = 1'b0;
        cmd("read_c1_stall", ID, 3'd0, 32'd1);
        stall = 1'b1;
        cmd("cfg_c1_clear", ID, 3'd1, 32'h22);
        cmd("read_c1_after_clear", ID, 3'd0, 32'd1);
        stall = 1'b0;

        cmd("cfg_clear_all", ID, 3'd1, 32'hFF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            stall   = 1'($urandom_range(0, 1));
            busIdle = 1'($urandom_range(0, 1));
        end
        @(negedge clock) begin stall = 1'b0; busIdle = 1'b0; end
        for (int i = 0; i < 4; i++) cmd("read_rand", ID, 3'd0, 32'(i));
        cmd("op6", ID, 3'd6, 32'h1234);

        cmd("period50", ID, 3'd2, 32'd50);
        for (int k = 0; k < 300 && !(m_q.size() == 4 && m_busy == 0); k++) @(negedge clock);
        check("p50_wait", 32'(m_q.size() == 4 && m_busy == 0), 32'd1);
        cmd("period_off", ID, 3'd2, 32'd0);
        for (int i = 0; i < 4; i++) cmd("p50_pop", ID, 3'd3, 32'd0);
        cmd("p50_status", ID, 3'd4, 32'd0);
        cmd("pop_empty", ID, 3'd3, 32'd0);

        cmd("period10", ID, 3'd2, 32'd10);
        waitCycles(60);
        cmd("period_off2", ID, 3'd2, 32'd0);
        cmd("full_status", ID, 3'd4, 32'd0);
        popThenIgnored();
        cmd("status_after_ignored", ID, 3'd4, 32'd0);
        cmd("ack", ID, 3'd5, 32'd0);
        cmd("status_after_ack", ID, 3'd4, 32'd0);
        n = m_q.size();
        for (int i = 0; i < n; i++) cmd("drain", ID, 3'd3, 32'd0);

        cmd("period20", ID, 3'd2, 32'd20);
        for (int k = 0; k < 100 && m_busy != 3; k++) @(negedge clock);
        check("cap1_wait", 32'(m_busy), 32'd3);
        cmd("pop_in_cap2", ID, 3'd3, 32'd0);
        cmd("period_off3", ID, 3'd2, 32'd0);
        cmd("cap2_status", ID, 3'd4, 32'd0);
        n = m_q.size();
        for (int i = 0; i < n; i++) cmd("cap2_drain", ID, 3'd3, 32'd0);

        cmd("period5", ID, 3'd2, 32'd5);
        for (int k = 0; k < 100 && m_busy != 3; k++) @(negedge clock);
        check("rst_cap1_wait", 32'(m_busy), 32'd3);
        reset = 1'b1;
        #1;
        check("rst_mid_done", 32'(ci.done), 32'd0);
        @(negedge clock) reset = 1'b0;
        cmd("rst_mid_status", ID, 3'd4, 32'd0);
        cmd("rst_mid_read0", ID, 3'd0, 32'd0);
        cmd("rst_mid_pop", ID, 3'd3, 32'd0);

        cmd("stress_cfg", ID, 3'd1, 32'h0F);
        cmd("period1", ID, 3'd2, 32'd1);
        waitCycles(30);
        cmd("period_off4", ID, 3'd2, 32'd0);
        waitCycles(6);
        cmd("stress_status", ID, 3'd4, 32'd0);
        n = m_q.size();
        for (int i = 0; i < n; i++) cmd("stress_pop", ID, 3'd3, 32'd0);
        cmd("stress_empty", ID, 3'd3, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/profile_sampler_ci.md
Name: profile_sampler_ci

Overview:
- Custom-instruction profiling controller: owns four 32-bit event counters (cycles, stall cycles, bus-idle cycles, user cycles) and configures their enable/clear state.
- Sequences periodic snapshots of all four counters into an on-chip sample FIFO, so software can drain samples later without polling at sample time.
- Sits on the CPU custom-instruction port beside other CI blocks and responds only when ciN matches customId.

Parameters:
- customId, 8'd9, custom-instruction number this block answers to.
- FIFO_DEPTH, 16, sample FIFO entries (32-bit each); power of two, multiple of 4, >= 4.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  CI start pulse, one cycle
- ciN  in  8  CI number
- valueA  in  32  command: [2:0] opcode
- valueB  in  32  command operand
- stall  in  1  CPU stall indicator (event for counter1)
- busIdle  in  1  bus idle indicator (event for counter2)
- done  out  1  CI completion, one-cycle pulse
- result  out  32  CI result; valid only while done=1, otherwise 0

Behaviour:
- Reset (async): all counters 0, enable mask 0, period 0, timer 0, FIFO empty, overflow 0, drop count 0, FSM IDLE, done=0, result=0.
- Counters: c0 += 1 when en[0]; c1 += 1 when en[1]&stall; c2 += 1 when en[2]&busIdle; c3 += 1 when en[3]. 32-bit wrap (0xFFFFFFFF -> 0). A clear has priority over increment in the same cycle.
- A command is accepted when start=1 and ciN==customId. Other ciN values are ignored: done=0, no state change.
- Opcodes:
  - 0 READ: result = live counter valueB[1:0], sampled the same cycle; done in the same cycle.
  - 1 CONFIG: en <= valueB[3:0]; selected counters cleared where valueB[7:4] is 1, on the next edge; done in the same cycle; result 0.
  - 2 PERIOD: period <= valueB; timer <= valueB; done in the same cycle; result 0. A period of 0 disables sampling.
  - 3 POP: registered read; done one cycle after start. result = oldest FIFO entry, which is removed. If the FIFO is empty, result = 0xFFFFFFFF and nothing is removed.
  - 4 STATUS: result = {drops[15:0], overflow, 7'b0, fill count[7:0]}; done in the same cycle.
  - 5 ACK: overflow <= 0; drops <= 0; done in the same cycle.
  - 6,7: done in the same cycle; result 0; no effect.
- While a POP is pending (the cycle after start), a new start is ignored.
- Timer (period != 0): decrements every cycle. When timer==1 it reloads with period and raises a tick. A period of 1 therefore ticks every cycle.
- FSM states IDLE, CAP0, CAP1, CAP2, CAP3.
  - In IDLE, on a tick: if free entries >= 4, latch all four counters into shadow registers in the same edge and go to CAP0. Otherwise drop the sample: overflow <= 1, drops saturating +1.
  - CAPn writes shadow n to the FIFO, then moves to CAPn+1. CAP3 returns to IDLE.
  - A tick arriving while not in IDLE is dropped (overflow/drops as above).
- Sample layout in the FIFO: c0, c1, c2, c3, in that order. Samples are always whole.
- A FIFO push (capture) and pop in the same cycle are both performed; fill count is unchanged.
- A clear or CONFIG during capture does not affect shadow values already latched.
- A PERIOD write during capture reloads the timer; the capture in progress completes.
- Asserting reset mid-capture or mid-POP aborts to the reset state: no done pulse, FIFO empty.

Test Plan:
- CONFIG valueB=0x0F, wait 100 cycles, READ valueB=0 -> result = 100 ± fixed offset (bench computes exact: count of edges after CONFIG edge); READ with ciN=8 -> done=0, result=0.
- Hold stall high 10 cycles with en=0x2, READ valueB=1 -> 10; CONFIG valueB=0x22 (clear+enable c1) then READ -> 0 or 1 per edge timing, checked exactly.
- PERIOD valueB=50, en=0xF: after first tick, POP ×4 -> c0..c3 snapshot values equal to the bench model at the tick edge; STATUS fill=0.
- FIFO_DEPTH=16, PERIOD 10, no pops for 60 cycles -> STATUS fill=16, overflow=1, drops=2; ACK -> overflow=0, drops=0.
- POP on empty FIFO -> done exactly one cycle after start, result=0xFFFFFFFF; POP issued during CAP2 -> returns the oldest entry, fill count consistent.
- Assert reset during CAP1 -> FIFO empty, counters 0, done=0; period=1 stress -> every sample is a complete 4-word group and drops increment on every busy tick.
